sha3_padder: RTL

//   Message padder directly upstream of the Keccak f-permutation core. Packs 32-bit

---
 rtl/sha3_padder.sv | 114 +++++++++++
 1 files changed

// File: rtl/sha3_padder.sv
// SHA-3 message padder: packs 32-bit words into rate blocks
// and appends domain/pad bytes ahead of the Keccak core.
module sha3_padder #(
  parameter int         RATE_WORDS = 18,
  parameter logic [7:0] PAD_FIRST  = 8'h06
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             in,
  input  logic [1:0]              byte_num,
  input  logic                    is_last,
  input  logic                    in_ready,
  output logic                    in_ack,
  output logic                    buffer_full,
  output logic [32*RATE_WORDS-1:0] out,
  output logic                    out_ready,
  input  logic                    f_ack
);

  localparam int W  = 32 * RATE_WORDS;
  localparam int CW = $clog2(RATE_WORDS + 1);

  typedef enum logic [1:0] {
    FILL,
    PAD,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] count;
  logic          last_slot;
  logic          shift;
  logic [31:0]   word;
  logic [31:0]   keep;
  logic [31:0]   pad;
  logic [31:0]   tail_word;

  assign last_slot   = (count == CW'(RATE_WORDS - 1));
  assign buffer_full = (count == CW'(RATE_WORDS));
  assign out_ready   = buffer_full;
  assign in_ack      = in_ready & (state == FILL) & ~buffer_full;

  // Final word: keep valid MSB bytes, pad byte right after them.
  always_comb begin
    keep = '0;
    pad  = '0;
    unique case (byte_num)
      2'd0: begin
        keep = 32'h00000000;
        pad  = {PAD_FIRST, 24'h0};
      end
      2'd1: begin
        keep = 32'hFF000000;
        pad  = {8'h0, PAD_FIRST, 16'h0};
      end
      2'd2: begin
        keep = 32'hFFFF0000;
        pad  = {16'h0, PAD_FIRST, 8'h0};
      end
      default: begin
        keep = 32'hFFFFFF00;
        pad  = {24'h0, PAD_FIRST};
      end
    endcase
    tail_word = (in & keep) | pad;
    if (last_slot) tail_word = tail_word | 32'h80;
  end

  always_comb begin
    state_nxt = state;
    shift     = 1'b0;
    word      = in;
    unique case (state)
      FILL: begin
        if (in_ack) begin
          shift = 1'b1;
          if (is_last) begin
            word      = tail_word;
            state_nxt = last_slot ? DONE : PAD;
          end
        end
      end
      PAD: begin
        if (!buffer_full) begin
          shift = 1'b1;
          word  = last_slot ? 32'h80 : 32'h0;
          if (last_slot) state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = DONE;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FILL;
      count <= '0;
      out   <= '0;
    end else begin
      state <= state_nxt;
      if (buffer_full && f_ack) begin
        count <= '0;
      end else if (shift) begin
        out   <= {out[W-33:0], word};
        count <= count + 1'b1;
      end
    end
  end

endmodule
